// File: rtl/register_file_param.sv
// Parameterised register file with a per-register pending (scoreboard) bit.
// Register 0 is hard-wired to zero; optional same-cycle write-to-read forwarding.
module register_file_param #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH),
    parameter int BYPASS = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             regWrite,
    input  logic [AW-1:0]    writeRegister,
    input  logic [WIDTH-1:0] writeData,
    input  logic             reserve,
    input  logic [AW-1:0]    reserveRegister,
    input  logic [AW-1:0]    readRegister1,
    input  logic [AW-1:0]    readRegister2,
    output logic [WIDTH-1:0] readData1,
    output logic [WIDTH-1:0] readData2,
    output logic             busy1,
    output logic             busy2,
    output logic             anyBusy
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pending;

    logic             wr_en;
    logic             rsv_en;

    logic [AW-1:0]    raddr [2];
    logic [WIDTH-1:0] rdata [2];
    logic             rbusy [2];

    assign wr_en  = regWrite && (writeRegister != '0);
    assign rsv_en = reserve && (reserveRegister != '0);

    // Reserve is applied after the write so a same-register collision leaves the bit set.
    always_ff @(posedge clock) begin
        if (reset) begin
            regs    <= '{default: '0};
            pending <= '0;
        end else begin
            if (wr_en) begin
                regs[writeRegister]    <= writeData;
                pending[writeRegister] <= 1'b0;
            end
            if (rsv_en) begin
                pending[reserveRegister] <= 1'b1;
            end
        end
    end

    assign raddr[0] = readRegister1;
    assign raddr[1] = readRegister2;

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rdata[p] = regs[raddr[p]];
            rbusy[p] = pending[raddr[p]];
            if ((BYPASS != 0) && wr_en && (writeRegister == raddr[p])) begin
                rdata[p] = writeData;
                rbusy[p] = rsv_en && (reserveRegister == raddr[p]);
            end
            if (raddr[p] == '0) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end
        end
    end

    assign readData1 = rdata[0];
    assign readData2 = rdata[1];
    assign busy1     = rbusy[0];
    assign busy2     = rbusy[1];
    assign anyBusy   = |pending;

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench: 8x8 register files with and without forwarding, plus a 16x32 variant.
module tb_register_file_param;

    logic       clock = 1'b0;
    logic       reset, regWrite, reserve;
    logic [2:0] writeRegister, reserveRegister, rr1, rr2;
    logic [7:0] writeData;

    logic [7:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic       a_b1, a_b2, a_any, b_b1, b_b2, b_any;

    logic        w_reset, w_regWrite, w_reserve;
    logic [4:0]  w_wr, w_rsv, w_rr1, w_rr2;
    logic [15:0] w_wd, w_rd1, w_rd2;
    logic        w_b1, w_b2, w_any;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    register_file_param #(.WIDTH(8), .DEPTH(8), .BYPASS(1)) dut_a (
        .clock(clock), .reset(reset), .regWrite(regWrite), .writeRegister(writeRegister),
        .writeData(writeData), .reserve(reserve), .reserveRegister(reserveRegister),
        .readRegister1(rr1), .readRegister2(rr2), .readData1(a_rd1), .readData2(a_rd2),
        .busy1(a_b1), .busy2(a_b2), .anyBusy(a_any)
    );

    register_file_param #(.WIDTH(8), .DEPTH(8), .BYPASS(0)) dut_b (
        .clock(clock), .reset(reset), .regWrite(regWrite), .writeRegister(writeRegister),
        .writeData(writeData), .reserve(reserve), .reserveRegister(reserveRegister),
        .readRegister1(rr1), .readRegister2(rr2), .readData1(b_rd1), .readData2(b_rd2),
        .busy1(b_b1), .busy2(b_b2), .anyBusy(b_any)
    );

    register_file_param #(.WIDTH(16), .DEPTH(32), .BYPASS(1)) dut_w (
        .clock(clock), .reset(w_reset), .regWrite(w_regWrite), .writeRegister(w_wr),
        .writeData(w_wd), .reserve(w_reserve), .reserveRegister(w_rsv),
        .readRegister1(w_rr1), .readRegister2(w_rr2), .readData1(w_rd1), .readData2(w_rd2),
        .busy1(w_b1), .busy2(w_b2), .anyBusy(w_any)
    );

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later still.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; regWrite = 1'b0; reserve = 1'b0;
        writeRegister = '0; reserveRegister = '0; writeData = '0;
        w_reset = 1'b0; w_regWrite = 1'b0; w_reserve = 1'b0;
        w_wr = '0; w_rsv = '0; w_wd = '0;
    endtask

    task automatic test_reset();
        idle();
        rr1 = '0; rr2 = '0; w_rr1 = '0; w_rr2 = '0;
        reset = 1'b1; w_reset = 1'b1;
        tick();
        // Write and reserve alongside reset must be ignored.
        regWrite = 1'b1; writeRegister = 3'd3; writeData = 8'h5A;
        reserve = 1'b1; reserveRegister = 3'd4;
        tick();
        idle();
        for (int r = 1; r < 8; r++) begin
            rr1 = 3'(r); rr2 = 3'(8 - r);
            #1;
            checks++;
            if (a_rd1 !== 8'h00 || a_rd2 !== 8'h00) begin
                failures++; $display("FAIL reset_data_a r=%0d got=%h/%h exp=00/00", r, a_rd1, a_rd2);
            end
            checks++;
            if (a_b1 !== 1'b0 || a_b2 !== 1'b0 || a_any !== 1'b0) begin
                failures++; $display("FAIL reset_busy_a r=%0d got=%b%b%b exp=000", r, a_b1, a_b2, a_any);
            end
            checks++;
            if (b_rd1 !== 8'h00 || b_rd2 !== 8'h00 || b_b1 !== 1'b0 || b_any !== 1'b0) begin
                failures++; $display("FAIL reset_b r=%0d got=%h/%h/%b/%b exp=00/00/0/0", r, b_rd1, b_rd2, b_b1, b_any);
            end
        end
    endtask

    task automatic test_write_read();
        idle();
        regWrite = 1'b1; writeRegister = 3'd3; writeData = 8'hA5;
        tick();
        idle();
        rr1 = 3'd3; rr2 = 3'd3;
        #1;
        checks++;
        if (a_rd1 !== 8'hA5 || a_rd2 !== 8'hA5) begin
            failures++; $display("FAIL write_read_a got=%h/%h exp=a5/a5", a_rd1, a_rd2);
        end
        checks++;
        if (b_rd1 !== 8'hA5 || b_rd2 !== 8'hA5) begin
            failures++; $display("FAIL write_read_b got=%h/%h exp=a5/a5", b_rd1, b_rd2);
        end
        regWrite = 1'b1; writeRegister = 3'd0; writeData = 8'hFF;
        rr1 = 3'd0; rr2 = 3'd0;
        #1;
        checks++;
        if (a_rd1 !== 8'h00) begin
            failures++; $display("FAIL r0_bypass got=%h exp=00", a_rd1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (a_rd1 !== 8'h00 || a_rd2 !== 8'h00 || b_rd1 !== 8'h00) begin
            failures++; $display("FAIL r0_write got=%h/%h/%h exp=00/00/00", a_rd1, a_rd2, b_rd1);
        end
    endtask

    task automatic test_bypass();
        idle();
        rr1 = 3'd5; rr2 = 3'd3;
        regWrite = 1'b1; writeRegister = 3'd5; writeData = 8'h3C;
        #1;
        checks++;
        if (a_rd1 !== 8'h3C || a_b1 !== 1'b0) begin
            failures++; $display("FAIL bypass_a got=%h/%b exp=3c/0", a_rd1, a_b1);
        end
        checks++;
        if (b_rd1 !== 8'h00) begin
            failures++; $display("FAIL nobypass_b got=%h exp=00", b_rd1);
        end
        checks++;
        if (a_rd2 !== 8'hA5) begin
            failures++; $display("FAIL bypass_other_port got=%h exp=a5", a_rd2);
        end
        tick();
        idle();
        #1;
        checks++;
        if (b_rd1 !== 8'h3C || a_rd1 !== 8'h3C) begin
            failures++; $display("FAIL bypass_after_edge got=%h/%h exp=3c/3c", a_rd1, b_rd1);
        end
    endtask

    task automatic test_reserve();
        idle();
        reserve = 1'b1; reserveRegister = 3'd2;
        tick();
        idle();
        rr1 = 3'd2; rr2 = 3'd5;
        #1;
        checks++;
        if (a_b1 !== 1'b1 || a_any !== 1'b1 || a_b2 !== 1'b0) begin
            failures++; $display("FAIL reserve_a got=%b%b%b exp=110", a_b1, a_any, a_b2);
        end
        checks++;
        if (b_b1 !== 1'b1 || b_any !== 1'b1) begin
            failures++; $display("FAIL reserve_b got=%b%b exp=11", b_b1, b_any);
        end
        regWrite = 1'b1; writeRegister = 3'd2; writeData = 8'h11;
        #1;
        checks++;
        if (a_b1 !== 1'b0 || a_any !== 1'b1 || b_b1 !== 1'b1) begin
            failures++; $display("FAIL reserve_wr_cycle got=%b%b%b exp=011", a_b1, a_any, b_b1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (a_b1 !== 1'b0 || a_any !== 1'b0 || a_rd1 !== 8'h11) begin
            failures++; $display("FAIL reserve_cleared_a got=%b/%b/%h exp=0/0/11", a_b1, a_any, a_rd1);
        end
        checks++;
        if (b_b1 !== 1'b0 || b_any !== 1'b0 || b_rd1 !== 8'h11) begin
            failures++; $display("FAIL reserve_cleared_b got=%b/%b/%h exp=0/0/11", b_b1, b_any, b_rd1);
        end
    endtask

    task automatic test_reserve_write_same();
        idle();
        rr1 = 3'd4; rr2 = 3'd0;
        regWrite = 1'b1; writeRegister = 3'd4; writeData = 8'h77;
        reserve = 1'b1; reserveRegister = 3'd4;
        #1;
        checks++;
        if (a_rd1 !== 8'h77 || a_b1 !== 1'b1) begin
            failures++; $display("FAIL same_cycle_bypass got=%h/%b exp=77/1", a_rd1, a_b1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (a_rd1 !== 8'h77 || a_b1 !== 1'b1 || a_any !== 1'b1) begin
            failures++; $display("FAIL same_reg_a got=%h/%b/%b exp=77/1/1", a_rd1, a_b1, a_any);
        end
        checks++;
        if (b_rd1 !== 8'h77 || b_b1 !== 1'b1) begin
            failures++; $display("FAIL same_reg_b got=%h/%b exp=77/1", b_rd1, b_b1);
        end
        reserve = 1'b1; reserveRegister = 3'd0;
        tick();
        idle();
        #1;
        checks++;
        if (a_b2 !== 1'b0 || b_b2 !== 1'b0) begin
            failures++; $display("FAIL reserve_r0 got=%b/%b exp=0/0", a_b2, b_b2);
        end
        regWrite = 1'b1; writeRegister = 3'd4; writeData = 8'h12;
        reserve = 1'b1; reserveRegister = 3'd7;
        tick();
        idle();
        rr1 = 3'd4; rr2 = 3'd7;
        #1;
        checks++;
        if (a_rd1 !== 8'h12 || a_b1 !== 1'b0 || a_b2 !== 1'b1 || a_any !== 1'b1) begin
            failures++; $display("FAIL diff_regs got=%h/%b/%b/%b exp=12/0/1/1", a_rd1, a_b1, a_b2, a_any);
        end
    endtask

    task automatic test_reset_priority();
        idle();
        regWrite = 1'b1; writeRegister = 3'd6; writeData = 8'h99;
        reserve = 1'b1; reserveRegister = 3'd6;
        tick();
        idle();
        rr1 = 3'd6; rr2 = 3'd6;
        #1;
        checks++;
        if (a_rd1 !== 8'h99 || a_b1 !== 1'b1) begin
            failures++; $display("FAIL pre_reset got=%h/%b exp=99/1", a_rd1, a_b1);
        end
        reset = 1'b1; regWrite = 1'b1; writeRegister = 3'd6; writeData = 8'h42;
        tick();
        idle();
        #1;
        checks++;
        if (a_rd1 !== 8'h00 || a_rd2 !== 8'h00 || a_any !== 1'b0 || a_b1 !== 1'b0) begin
            failures++; $display("FAIL reset_prio_a got=%h/%h/%b/%b exp=00/00/0/0", a_rd1, a_rd2, a_any, a_b1);
        end
        checks++;
        if (b_rd1 !== 8'h00 || b_any !== 1'b0) begin
            failures++; $display("FAIL reset_prio_b got=%h/%b exp=00/0", b_rd1, b_any);
        end
        rr1 = 3'd5;
        #1;
        checks++;
        if (a_rd1 !== 8'h00) begin
            failures++; $display("FAIL reset_r5 got=%h exp=00", a_rd1);
        end
    endtask

    task automatic test_wide();
        idle();
        w_rr1 = 5'd31; w_rr2 = 5'd0;
        w_regWrite = 1'b1; w_wr = 5'd31; w_wd = 16'hBEEF;
        #1;
        checks++;
        if (w_rd1 !== 16'hBEEF) begin
            failures++; $display("FAIL wide_bypass got=%h exp=beef", w_rd1);
        end
        tick();
        idle();
        w_rr2 = 5'd31;
        #1;
        checks++;
        if (w_rd1 !== 16'hBEEF || w_rd2 !== 16'hBEEF) begin
            failures++; $display("FAIL wide_r31 got=%h/%h exp=beef/beef", w_rd1, w_rd2);
        end
        w_reserve = 1'b1; w_rsv = 5'd17;
        tick();
        idle();
        w_rr1 = 5'd17;
        #1;
        checks++;
        if (w_b1 !== 1'b1 || w_any !== 1'b1 || w_b2 !== 1'b0) begin
            failures++; $display("FAIL wide_reserve got=%b%b%b exp=110", w_b1, w_any, w_b2);
        end
        w_reset = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if (w_any !== 1'b0 || w_rd2 !== 16'h0000) begin
            failures++; $display("FAIL wide_reset got=%b/%h exp=0/0000", w_any, w_rd2);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        regWrite = 1'b1; writeRegister = 3'd1; writeData = 8'h11;
        tick();
        writeRegister = 3'd2; writeData = 8'h22;
        tick();
        writeRegister = 3'd1; writeData = 8'hE1;
        tick();
        idle();
        rr1 = 3'd1; rr2 = 3'd2;
        #1;
        checks++;
        if (a_rd1 !== 8'hE1 || a_rd2 !== 8'h22) begin
            failures++; $display("FAIL b2b_a got=%h/%h exp=e1/22", a_rd1, a_rd2);
        end
        checks++;
        if (b_rd1 !== 8'hE1 || b_rd2 !== 8'h22) begin
            failures++; $display("FAIL b2b_b got=%h/%h exp=e1/22", b_rd1, b_rd2);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_reserve();
        test_reserve_write_same();
        test_reset_priority();
        test_wide();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits of every register.
REQ-002 Parameter DEPTH, default 8, number of registers; power of two, at least 2.
REQ-003 Parameter AW, default $clog2(DEPTH), register address width.
REQ-004 Parameter BYPASS, default 1, 1 = same-cycle write forwarded to read ports, 0 = reads return stored value only.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 regWrite  input  1  write enable.
REQ-008 writeRegister  input  AW  write address.
REQ-009 writeData  input  WIDTH  write data.
REQ-010 reserve  input  1  mark a register as awaiting a pending write (scoreboard set).
REQ-011 reserveRegister  input  AW  register to mark pending.
REQ-012 readRegister1, readRegister2  input  AW each  read addresses.
REQ-013 readData1, readData2  output  WIDTH each  combinational read data.
REQ-014 busy1, busy2  output  1 each  pending flag of readRegister1 / readRegister2.
REQ-015 anyBusy  output  1  OR of all pending flags.

Function
REQ-016 Storage SHALL be DEPTH x WIDTH registers plus DEPTH pending bits; updates on rising clock edge only.
REQ-017 Register 0 SHALL always read 0 and never be pending; writes and reserves addressed to 0 are ignored.
REQ-018 regWrite=1, writeRegister!=0: register[writeRegister] <= writeData at the edge; its pending bit cleared at the same edge.
REQ-019 reserve=1, reserveRegister!=0: pending bit of reserveRegister set at the edge.
REQ-020 reserve and regWrite same cycle, same nonzero register: data written AND pending bit left set (reserve wins; new producer outstanding).
REQ-021 reserve and regWrite same cycle, different registers: both take effect independently.
REQ-022 Reads SHALL be combinational, zero latency: readDataN = register[readRegisterN].
REQ-023 BYPASS=1: if regWrite=1, writeRegister=readRegisterN, and address != 0, readDataN SHALL equal writeData in that cycle and busyN SHALL be 0 unless REQ-024 applies.
REQ-024 BYPASS=1 with reserve to the same register in that cycle: busyN SHALL stay 1.
REQ-025 BYPASS=0: read ports SHALL show pre-edge stored value and stored pending bit.
REQ-026 busyN SHALL reflect pending bit of readRegisterN (post-bypass per REQ-023); both read ports may address the same register and SHALL return identical values.
REQ-027 anyBusy SHALL be the OR of stored pending bits (no bypass).
REQ-028 Address out of range (AW bits exceed DEPTH-1 cannot occur since DEPTH is a power of two); no range check required.

Reset
REQ-029 reset=1 at a rising edge: all registers <= 0, all pending bits <= 0; takes priority over regWrite and reserve that cycle.
REQ-030 After reset, all readData = 0, busy1 = busy2 = anyBusy = 0, until the first write/reserve edge.
REQ-031 reset asserted mid-sequence (pending bits set) SHALL clear them in the same edge; no partial state kept.

Verification (WIDTH=8, DEPTH=8 unless stated)
REQ-032 Reset, then read r1..r7 -> all readData 0, busy1=busy2=anyBusy=0.
REQ-033 Write r3=8'hA5, next cycle read r3 on both ports -> readData1=readData2=8'hA5; write r0=8'hFF -> read r0 = 8'h00.
REQ-034 BYPASS=1: regWrite r5=8'h3C with readRegister1=5 same cycle -> readData1=8'h3C before edge; BYPASS=0 -> old value 8'h00 until after edge.
REQ-035 reserve r2, next cycle busy1(r2)=1, anyBusy=1; write r2=8'h11 -> after edge busy1=0, anyBusy=0, readData1=8'h11.
REQ-036 Same-cycle reserve and write r4=8'h77 -> after edge readData r4=8'h77, busy=1; reserve r0 -> busy stays 0.
REQ-037 With r6 pending and r6=8'h99, assert reset together with regWrite r6=8'h42 -> after edge r6=8'h00, anyBusy=0; repeat with WIDTH=16, DEPTH=32 writing r31=16'hBEEF -> reads back 16'hBEEF.
